// File: rtl/hm_value_formatter.sv
// Captures a 16-bit value on a start edge, converts it to BCD with a sequential
// double-dabble and streams "V=<digits>\r\n" into a UART transmitter via start/busy.
module hm_value_formatter #(
  parameter bit LEADING_ZEROS = 1'b1
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, CONVERT, LOAD, SEND, WAIT_ACK, WAIT_DONE, NEXT, FINISH
  } state_t;

  state_t      state;
  logic        start_q;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [3:0]  iter;
  logic [3:0]  idx;
  logic [19:0] bcd_adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [19:0] adjust(input logic [19:0] b);
    adjust = {add3(b[19:16]), add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
  endfunction

  // First digit position (2..6) holding a nonzero digit; the units digit is always sent.
  function automatic logic [3:0] first_idx(input logic [19:0] b);
    if (b[19:16] != 4'd0)      first_idx = 4'd2;
    else if (b[15:12] != 4'd0) first_idx = 4'd3;
    else if (b[11:8] != 4'd0)  first_idx = 4'd4;
    else if (b[7:4] != 4'd0)   first_idx = 4'd5;
    else                       first_idx = 4'd6;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [19:0] b);
    case (i)
      4'd0:    frame_byte = 8'h56;
      4'd1:    frame_byte = 8'h3D;
      4'd2:    frame_byte = {4'h3, b[19:16]};
      4'd3:    frame_byte = {4'h3, b[15:12]};
      4'd4:    frame_byte = {4'h3, b[11:8]};
      4'd5:    frame_byte = {4'h3, b[7:4]};
      4'd6:    frame_byte = {4'h3, b[3:0]};
      4'd7:    frame_byte = 8'h0D;
      4'd8:    frame_byte = 8'h0A;
      default: frame_byte = 8'h00;
    endcase
  endfunction

  assign bcd_adj = adjust(bcd);

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      bin      <= 16'd0;
      bcd      <= 20'd0;
      iter     <= 4'd0;
      idx      <= 4'd0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !start_q) begin
            bin   <= value;
            bcd   <= 20'd0;
            iter  <= 4'd0;
            idx   <= 4'd0;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
          iter       <= iter + 4'd1;
          if (iter == 4'd15) state <= LOAD;
        end
        LOAD: begin
          tx_data <= frame_byte(idx, bcd);
          // Never offer a byte while the serializer is still busy.
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_start <= 1'b0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= NEXT;
        end
        NEXT: begin
          if (idx == 4'd8) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else begin
            if (idx == 4'd1 && !LEADING_ZEROS) idx <= first_idx(bcd);
            else                               idx <= idx + 4'd1;
            state <= LOAD;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hm_value_formatter.sv
// Bench for hm_value_formatter: two instances (with and without leading zeros) share
// stimulus; each has its own transmitter model and byte scoreboard.
module tb_hm_value_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = 16'd0;
  logic        tx_busy1 = 1'b0, tx_busy0 = 1'b0;
  logic [7:0]  tx_data1, tx_data0;
  logic        tx_start1, tx_start0, busy1, busy0, done1, done0;
  int          cnt1 = 0, cnt0 = 0;
  int          done_cnt1 = 0, done_cnt0 = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  exp1[$];
  logic [7:0]  exp0[$];

  always #10 clk = ~clk;

  hm_value_formatter #(.LEADING_ZEROS(1'b1)) u_lz1 (
    .clk_50mhz(clk), .rst(rst), .start(start), .value(value), .tx_busy(tx_busy1),
    .tx_data(tx_data1), .tx_start(tx_start1), .busy(busy1), .done(done1));

  hm_value_formatter #(.LEADING_ZEROS(1'b0)) u_lz0 (
    .clk_50mhz(clk), .rst(rst), .start(start), .value(value), .tx_busy(tx_busy0),
    .tx_data(tx_data0), .tx_start(tx_start0), .busy(busy0), .done(done0));

  // Transmitter models: busy rises the cycle after tx_start and stays high 20 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy1 <= 1'b0; cnt1 <= 0;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) tx_busy1 <= 1'b0;
    end else if (tx_start1) begin
      tx_busy1 <= 1'b1; cnt1 <= 20;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy0 <= 1'b0; cnt0 <= 0;
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) tx_busy0 <= 1'b0;
    end else if (tx_start0) begin
      tx_busy0 <= 1'b1; cnt0 <= 20;
    end
  end

  // Scoreboards: each offered byte is popped against the expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start1) begin
        checks++;
        if (tx_busy1) begin
          errors++; $display("FAIL lz1_start_while_busy: tx_busy=%b required 0", tx_busy1);
        end else if (exp1.size() == 0) begin
          errors++; $display("FAIL lz1_unexpected_byte: got %h, none expected", tx_data1);
        end else if (tx_data1 !== exp1[0]) begin
          errors++; $display("FAIL lz1_byte: got %h expected %h", tx_data1, exp1[0]);
        end
        if (exp1.size() != 0) void'(exp1.pop_front());
      end
      if (done1) done_cnt1++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start0) begin
        checks++;
        if (tx_busy0) begin
          errors++; $display("FAIL lz0_start_while_busy: tx_busy=%b required 0", tx_busy0);
        end else if (exp0.size() == 0) begin
          errors++; $display("FAIL lz0_unexpected_byte: got %h, none expected", tx_data0);
        end else if (tx_data0 !== exp0[0]) begin
          errors++; $display("FAIL lz0_byte: got %h expected %h", tx_data0, exp0[0]);
        end
        if (exp0.size() != 0) void'(exp0.pop_front());
      end
      if (done0) done_cnt0++;
    end
  end

  task automatic push_expected(input int v);
    int d[5];
    bit nz;
    d[4] = v / 10000; d[3] = (v / 1000) % 10; d[2] = (v / 100) % 10;
    d[1] = (v / 10) % 10; d[0] = v % 10;
    exp1.push_back(8'h56); exp1.push_back(8'h3D);
    exp0.push_back(8'h56); exp0.push_back(8'h3D);
    nz = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      exp1.push_back(8'h30 + 8'(d[k]));
      if (d[k] != 0 || k == 0) nz = 1'b1;
      if (nz) exp0.push_back(8'h30 + 8'(d[k]));
    end
    exp1.push_back(8'h0D); exp1.push_back(8'h0A);
    exp0.push_back(8'h0D); exp0.push_back(8'h0A);
  endtask

  task automatic wait_frames(input int b1, input int b0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_cnt1 > b1 && done_cnt0 > b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_data1, tx_start1, busy1, done1, tx_data0, tx_start0, busy0, done0} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: lz1 %h/%b/%b/%b lz0 %h/%b/%b/%b required all 0",
               tx_data1, tx_start1, busy1, done1, tx_data0, tx_start0, busy0, done0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start1, busy1, tx_start0, busy0} !== 4'd0) begin
      errors++; $display("FAIL idle_after_reset: busy1=%b busy0=%b required 0", busy1, busy0);
    end
  endtask

  task automatic run_value(input string name, input int v, input bit check_latency);
    int b1, b0, n;
    bit ok;
    b1 = done_cnt1; b0 = done_cnt0;
    value = 16'(v);
    push_expected(v);
    start = 1'b1;
    n = 0;
    if (check_latency) begin
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); n++;
        @(negedge clk);
        if (tx_start1) break;
      end
      checks++;
      if (n != 18 || tx_start0 !== 1'b1) begin
        errors++;
        $display("FAIL %s_latency: first tx_start after %0d cycles (lz0=%b) required 18", name, n, tx_start0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_frames(b1, b0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_timeout: done not seen within bound", name);
    end
    @(negedge clk);
    checks++;
    if (exp1.size() != 0 || exp0.size() != 0 || busy1 !== 1'b0 || busy0 !== 1'b0 ||
        done_cnt1 != b1 + 1 || done_cnt0 != b0 + 1) begin
      errors++;
      $display("FAIL %s_frame_end: left %0d/%0d bytes, busy %b/%b, dones %0d/%0d required 0/0, 0/0, 1/1",
               name, exp1.size(), exp0.size(), busy1, busy0, done_cnt1 - b1, done_cnt0 - b0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_held();
    int b1, b0;
    bit ok;
    b1 = done_cnt1; b0 = done_cnt0;
    value = 16'd12345;
    push_expected(12345);
    start = 1'b1;
    repeat (60) @(negedge clk);
    value = 16'd999;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_frames(b1, b0, ok);
    repeat (30) @(negedge clk);
    checks++;
    if (!ok || exp1.size() != 0 || exp0.size() != 0 ||
        done_cnt1 != b1 + 1 || done_cnt0 != b0 + 1) begin
      errors++;
      $display("FAIL held_single_frame: ok=%b left %0d/%0d dones %0d/%0d required 1, 0/0, 1/1",
               ok, exp1.size(), exp0.size(), done_cnt1 - b1, done_cnt0 - b0);
    end
    run_value("held_second", 12345, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    value = 16'd12345;
    push_expected(12345);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 1000 && pulses < 4; i++) begin
      @(posedge clk); #1;
      if (tx_start1) pulses++;
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL abort_reach_byte4: saw %0d tx_start pulses required 4", pulses);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_start1, busy1, tx_start0, busy0} !== 4'd0) begin
      errors++;
      $display("FAIL abort_outputs: tx_start %b/%b busy %b/%b required 0", tx_start1, tx_start0, busy1, busy0);
    end
    exp1.delete();
    exp0.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_value("after_abort", 7, 1'b1);
  endtask

  initial begin
    test_reset();
    run_value("v12345", 12345, 1'b1);
    run_value("v42", 42, 1'b0);
    run_value("v0", 0, 1'b0);
    run_value("v65535", 65535, 1'b0);
    run_value("v10000", 10000, 1'b0);
    run_value("v305", 305, 1'b0);
    test_start_held();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
